// File: rtl/i2s_audio_tx_if.sv
// Stereo PCM sample handshake between the sample source and the I2S serializer.
// Latency: n/a (signal bundle only).
// Backpressure: the consumer deasserts sample_ready while it cannot take a pair.
//
// Ports (modport slave = serializer side):
//   sample_l, sample_r : DATA_W two's-complement PCM, left and right
//   sample_valid       : a pair is offered
//   sample_ready       : the consumer accepts the pair this cycle
interface i2s_audio_tx_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] sample_l;
    logic [DATA_W-1:0] sample_r;
    logic              sample_valid;
    logic              sample_ready;

    modport master (
        output sample_l,
        output sample_r,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_l,
        input  sample_r,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/i2s_audio_tx.sv
// I2S transmitter: buffers stereo PCM pairs and serializes them MSB first for an external DAC.
// Latency: a buffered pair starts on audio_dac at the next frame load (left MSB at frame bit 0).
// Backpressure: sample_ready drops while the 2-entry buffer is full; pairs pop only at frame load.
//
// Ports:
//   clk_audio, reset_n : audio master clock, asynchronous active-low reset
//   smp                : sample handshake (i2s_audio_tx_if.slave)
//   audio_sclk         : bit clock, clk_audio / SCLK_DIV
//   audio_lrck         : word select, 0 = left, 1 = right, leads data by one bit
//   audio_dac          : serial data, stable across each audio_sclk rising edge
//   frame_start        : one-cycle pulse when frame bit 0 begins
//   underrun           : one-cycle pulse when a frame starts with no buffered pair
module i2s_audio_tx #(
    parameter int DATA_W    = 16,
    parameter int SCLK_DIV  = 4,
    parameter int SLOT_BITS = 32
) (
    input  logic           clk_audio,
    input  logic           reset_n,
    i2s_audio_tx_if.slave  smp,
    output logic           audio_sclk,
    output logic           audio_lrck,
    output logic           audio_dac,
    output logic           frame_start,
    output logic           underrun
);
    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int DIV_W      = (SCLK_DIV > 2) ? $clog2(SCLK_DIV) : 1;
    localparam int BIT_W      = $clog2(FRAME_BITS);

    typedef struct packed {
        logic [DATA_W-1:0] l;
        logic [DATA_W-1:0] r;
    } pair_t;

    logic [DIV_W-1:0]      div_cnt;
    logic [DIV_W-1:0]      div_nxt;
    logic                  tick;
    logic [BIT_W-1:0]      bit_cnt;
    logic [BIT_W-1:0]      bit_nxt;
    logic                  lrck_nxt;
    logic                  frame_load;
    logic [FRAME_BITS-1:0] shreg;
    logic [FRAME_BITS-1:0] frame_pat;
    pair_t                 last_pair;
    pair_t                 load_pair;

    // two-entry sample buffer
    pair_t                 mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;
    logic                  full;
    logic                  push;
    logic                  pop;

    // ---------------------------------------------------------------
    // Divider and frame position
    // ---------------------------------------------------------------
    assign tick       = (div_cnt == DIV_W'(SCLK_DIV - 1));
    assign div_nxt    = tick ? '0 : div_cnt + 1'b1;
    assign bit_nxt    = (bit_cnt == BIT_W'(FRAME_BITS - 1)) ? '0 : bit_cnt + 1'b1;
    assign frame_load = tick && (bit_nxt == '0);

    // Word select switches one bit early: it covers the last bit of the left slot
    // through the second-to-last bit of the right slot.
    assign lrck_nxt = (bit_nxt >= BIT_W'(SLOT_BITS - 1)) &&
                      (bit_nxt <= BIT_W'(FRAME_BITS - 2));

    // ---------------------------------------------------------------
    // Buffer control
    // ---------------------------------------------------------------
    assign full             = (count == 2'd2);
    assign smp.sample_ready = reset_n && !full;
    assign push             = smp.sample_valid && smp.sample_ready;
    assign pop              = frame_load && (count != 2'd0);

    // On an empty buffer the previous pair is replayed.
    assign load_pair = pop ? mem[rd_ptr] : last_pair;

    always_comb begin
        frame_pat = '0;
        frame_pat[FRAME_BITS-1 -: DATA_W] = load_pair.l;
        frame_pat[SLOT_BITS-1  -: DATA_W] = load_pair.r;
    end

    assign audio_dac = shreg[FRAME_BITS-1];

    // Storage only; validity is tracked by count, so no reset is needed.
    always_ff @(posedge clk_audio) begin
        if (push) begin
            mem[wr_ptr] <= '{l: smp.sample_l, r: smp.sample_r};
        end
    end

    always_ff @(posedge clk_audio or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt     <= '0;
            audio_sclk  <= 1'b0;
            bit_cnt     <= BIT_W'(FRAME_BITS - 1);
            audio_lrck  <= 1'b0;
            shreg       <= '0;
            last_pair   <= '0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
        end else begin
            div_cnt <= div_nxt;
            // Registered from the next divider value so SCLK falls on the same
            // edge that advances the data-side outputs.
            audio_sclk  <= (div_nxt >= DIV_W'(SCLK_DIV / 2));
            frame_start <= frame_load;
            underrun    <= frame_load && (count == 2'd0);

            if (tick) begin
                bit_cnt    <= bit_nxt;
                audio_lrck <= lrck_nxt;
                shreg      <= frame_load ? frame_pat : {shreg[FRAME_BITS-2:0], 1'b0};
            end

            if (pop) begin
                last_pair <= mem[rd_ptr];
                rd_ptr    <= ~rd_ptr;
            end
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end

            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_i2s_audio_tx.sv
module tb_i2s_audio_tx;
    localparam int DATA_W     = 16;
    localparam int SCLK_DIV   = 4;
    localparam int SLOT_BITS  = 32;
    localparam int FRAME_BITS = 2 * SLOT_BITS;

    logic clk_audio = 1'b0;
    logic reset_n;
    logic audio_sclk, audio_lrck, audio_dac, frame_start, underrun;

    always #5 clk_audio = ~clk_audio;

    i2s_audio_tx_if #(.DATA_W(DATA_W)) smp_if ();

    i2s_audio_tx #(
        .DATA_W    (DATA_W),
        .SCLK_DIV  (SCLK_DIV),
        .SLOT_BITS (SLOT_BITS)
    ) dut (
        .clk_audio   (clk_audio),
        .reset_n     (reset_n),
        .smp         (smp_if),
        .audio_sclk  (audio_sclk),
        .audio_lrck  (audio_lrck),
        .audio_dac   (audio_dac),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    // ---------------------------------------------------------------
    // Reference model: position in time since reset release, a queue of
    // accepted pairs and the pair currently being played.
    // ---------------------------------------------------------------
    int                t;
    logic [DATA_W-1:0] q_l [$];
    logic [DATA_W-1:0] q_r [$];
    logic [DATA_W-1:0] cur_l, cur_r;
    bit                exp_fs, exp_ur;

    function automatic bit load_at(input int tt);
        return (tt >= SCLK_DIV) && (tt % SCLK_DIV == 0) &&
               (((tt / SCLK_DIV) - 1) % FRAME_BITS == 0);
    endfunction

    function automatic int cur_b();
        return (t < SCLK_DIV) ? FRAME_BITS - 1 : ((t / SCLK_DIV) - 1) % FRAME_BITS;
    endfunction

    function automatic logic exp_dac();
        int b;
        b = cur_b();
        if (b < SLOT_BITS)
            return (b < DATA_W) ? cur_l[DATA_W-1-b] : 1'b0;
        else
            return (b - SLOT_BITS < DATA_W) ? cur_r[DATA_W-1-(b-SLOT_BITS)] : 1'b0;
    endfunction

    task automatic model_reset();
        t = 0;
        q_l.delete();
        q_r.delete();
        cur_l  = '0;
        cur_r  = '0;
        exp_fs = 1'b0;
        exp_ur = 1'b0;
    endtask

    task automatic check_outputs();
        int b;
        b = cur_b();
        check_eq("sample_ready", smp_if.sample_ready, reset_n && (q_l.size() < 2));
        check_eq("audio_sclk", audio_sclk, (t % SCLK_DIV) >= SCLK_DIV / 2);
        check_eq("audio_lrck", audio_lrck, (b >= SLOT_BITS - 1) && (b <= FRAME_BITS - 2));
        check_eq("audio_dac", audio_dac, exp_dac());
        check_eq("frame_start", frame_start, exp_fs);
        check_eq("underrun", underrun, exp_ur);
    endtask

    // One clock: capture what the DUT sees at the edge, advance the model, compare.
    task automatic step();
        bit                pre_v, pre_rst;
        int                pre_size;
        logic [DATA_W-1:0] pl, pr;
        bit                load;
        pre_v    = smp_if.sample_valid;
        pre_rst  = reset_n;
        pre_size = q_l.size();
        pl       = smp_if.sample_l;
        pr       = smp_if.sample_r;
        @(posedge clk_audio);
        #1;
        if (!pre_rst) begin
            model_reset();
        end else begin
            t++;
            load   = load_at(t);
            exp_fs = load;
            exp_ur = load && (pre_size == 0);
            if (load && pre_size > 0) begin
                cur_l = q_l.pop_front();
                cur_r = q_r.pop_front();
            end
            if (pre_v && pre_size < 2) begin
                q_l.push_back(pl);
                q_r.push_back(pr);
            end
        end
        check_outputs();
    endtask

    task automatic set_pair(input bit v, input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        smp_if.sample_valid = v;
        smp_if.sample_l     = l;
        smp_if.sample_r     = r;
    endtask

    task automatic run_to_b(input int target, input string tag);
        int i;
        for (i = 0; i < 2 * FRAME_BITS * SCLK_DIV && cur_b() != target; i++) step();
        check_eq(tag, cur_b(), target);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog t=%0t observed=timeout expected=finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        reset_n = 1'b0;
        set_pair(1'b1, DATA_W'($urandom), DATA_W'($urandom));
        model_reset();
        repeat (10) step();

        // Release and push the reference pair before the first frame.
        reset_n = 1'b1;
        set_pair(1'b1, 16'hA5C3, 16'h3C5A);
        step();
        set_pair(1'b0, '0, '0);
        repeat (300) step();

        // Random offers, buffer mostly full, backpressure exercised.
        repeat (1500) begin
            set_pair(($urandom_range(0, 99) < 3), DATA_W'($urandom), DATA_W'($urandom));
            step();
        end
        set_pair(1'b0, '0, '0);

        // Drain and underrun for several frames.
        repeat (4 * FRAME_BITS * SCLK_DIV) step();

        // Three back-to-back offers mid-frame; the third waits for the next pop.
        run_to_b(10, "wait_b10");
        set_pair(1'b1, 16'h1111, 16'h2222);
        step();
        set_pair(1'b1, 16'h3333, 16'h4444);
        step();
        set_pair(1'b1, 16'h5555, 16'h6666);
        step();
        check_eq("full_ready", smp_if.sample_ready, 1'b0);
        guard = 0;
        while (!smp_if.sample_ready && guard < 2 * FRAME_BITS * SCLK_DIV) begin
            step();
            guard++;
        end
        step();
        set_pair(1'b0, '0, '0);

        // One entry left buffered; offer a new pair exactly on the load edge.
        run_to_b(5, "wait_b5");
        guard = 0;
        while (q_l.size() != 1 && guard < 2 * FRAME_BITS * SCLK_DIV) begin
            step();
            guard++;
        end
        check_eq("one_buffered", q_l.size(), 1);
        guard = 0;
        while (!load_at(t + 1) && guard < 2 * FRAME_BITS * SCLK_DIV) begin
            step();
            guard++;
        end
        set_pair(1'b1, 16'h9ABC, 16'hDEF0);
        step();
        set_pair(1'b0, '0, '0);
        repeat (3 * FRAME_BITS * SCLK_DIV) step();

        // Reset asserted mid-frame: outputs must drop at once.
        run_to_b(20, "wait_b20");
        reset_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        repeat (5) step();
        reset_n = 1'b1;
        repeat (2 * FRAME_BITS * SCLK_DIV) begin
            set_pair(($urandom_range(0, 99) < 1), DATA_W'($urandom), DATA_W'($urandom));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/i2s_audio_tx.md
Name: i2s_audio_tx

Overview:
- Serializer fed by the audio PLL's 12.288 MHz output; drives the external I2S DAC.
- Accepts stereo PCM samples through a valid/ready handshake into a 2-entry buffer.
- Generates SCLK (MCLK/4 = 3.072 MHz), LRCK (48 kHz, 64 SCLK per frame) and serial data in standard I2S format.
- Entirely in the audio clock domain; the upstream sample source is already synchronized into it.

Parameters:
- DATA_W, 16: PCM sample width per channel, 1..32.
- SCLK_DIV, 4: clk_audio cycles per SCLK period; even, ≥2.
- SLOT_BITS, 32: SCLK bits per channel slot; ≥ DATA_W.

Ports:
- clk_audio  in  1  audio master clock, 12.288 MHz from the PLL.
- reset_n  in  1  asynchronous active-low reset.
- sample_l  in  DATA_W  left PCM, two's complement.
- sample_r  in  DATA_W  right PCM, two's complement.
- sample_valid  in  1  sample pair offered.
- sample_ready  out  1  buffer can accept a pair.
- audio_sclk  out  1  bit clock.
- audio_lrck  out  1  word select; 0 = left, 1 = right.
- audio_dac  out  1  serial data, MSB first.
- frame_start  out  1  one-cycle pulse when frame bit 0 begins.
- underrun  out  1  one-cycle pulse when a frame starts with the buffer empty.

Behaviour:
- Reset: all outputs 0; div_cnt=0; bit_cnt=2*SLOT_BITS-1; shift register 0; last-sample register 0; buffer empty. sample_ready is forced 0 while reset_n is low.
- Divider:
  - div_cnt counts 0..SCLK_DIV-1 and wraps.
  - audio_sclk is registered, high for div_cnt ≥ SCLK_DIV/2.
  - tick = (div_cnt == SCLK_DIV-1).
  - SCLK falls on the edge after tick; all data-side outputs update on that same edge, so data is stable at the SCLK rising edge.
- Frame: on each tick, bit_cnt increments and wraps 2*SLOT_BITS-1 -> 0. Default frame is 64 SCLK = 256 clk_audio cycles.
- LRCK, with I2S one-bit lead: audio_lrck=1 for b in [SLOT_BITS-1, 2*SLOT_BITS-2], otherwise 0.
- Data:
  - Left MSB at b=0, left bits at b=0..DATA_W-1, then zeros to b=SLOT_BITS-1.
  - Right MSB at b=SLOT_BITS, same layout.
  - audio_dac is the MSB of a 2*SLOT_BITS shift register that shifts left on each tick.
- Frame load, on the tick entering b=0:
  - Buffer non-empty: pop the oldest pair, load the shift register, and update the last-sample register.
  - Buffer empty: reload the last-sample register and pulse underrun.
  - In both cases frame_start pulses, and audio_dac shows the new left MSB in the same cycle.
- Buffer:
  - 2-entry FIFO; sample_ready = !full (combinational from a registered count).
  - Push when sample_valid && sample_ready; no push when full.
  - Push and pop in the same cycle: count unchanged, FIFO order preserved.
  - Pop happens only at frame load; this is the only read point.
- First frame: b=0 begins on the first tick after reset release, SCLK_DIV cycles after deassert.
- Reset mid-frame: everything aborts immediately to reset values, buffered samples are discarded, and the frame restarts from the first tick.
- No combinational path from sample_valid to any serial output.

Test Plan:
- Reset: hold reset_n low 10 cycles with sample_valid=1 -> all outputs 0, nothing accepted; after release, sample_ready=1 next cycle and frame_start pulses on cycle 4.
- Timing: free run -> audio_sclk period 4 cycles (2 high, 2 low); audio_lrck period 256 cycles, high for b=31..62; frame_start every 256 cycles.
- Serial data: push L=16'hA5C3, R=16'h3C5A before the first frame ->
  - b0..15 = 1010_0101_1100_0011, b16..31 = 0.
  - b32..47 = 0011_1100_0101_1010, b48..63 = 0.
  - Each bit stable across its SCLK rising edge.
- Full buffer: push 3 pairs back-to-back mid-frame -> first 2 accepted, sample_ready=0 on the third; after the next frame_start, sample_ready=1 the following cycle and the third pair is accepted.
- Underrun: one pair pushed, then none -> frame 1 plays the pair with no underrun; frames 2 and 3 replay the same pair with underrun pulsing coincident with frame_start.
- Simultaneous push/pop plus mid-frame reset:
  - One entry buffered, push asserted on the frame-load cycle -> count stays 1, the next frame plays the pushed pair.
  - Assert reset_n=0 at b=20 -> outputs 0 immediately, buffer empty, clean restart at b=0.
